// File: rtl/fc_train_seq_pkg.sv
// fc_train_seq_pkg: state encoding shared by the training sequencer.
// Rev 1.0
`default_nettype none

package fc_train_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_FW_FETCH = 3'd1,
        S_FW_SEND  = 3'd2,
        S_FW_REC   = 3'd3,
        S_BP_SEND  = 3'd4,
        S_BP_REC   = 3'd5,
        S_DONE     = 3'd6
    } state_e;

    localparam int DEF_DW   = 32;
    localparam int DEF_FRAC = 16;

endpackage

`default_nettype wire

// File: rtl/sm_sub_one.sv
// sm_sub_one: sign-magnitude x - ONE (saturating) when en_i, else x with -0 folded to +0.
// Rev 1.0
`default_nettype none

module sm_sub_one #(
    parameter int DW   = 32,
    parameter int FRAC = 16
) (
    input  logic [DW-1:0] a_i,
    input  logic          en_i,
    output logic [DW-1:0] y_o
);

    localparam logic [DW-1:0] ONE     = {{(DW-1){1'b0}}, 1'b1} << FRAC;
    localparam logic [DW-2:0] MAX_MAG = '1;

    logic [DW-2:0] w_mag;
    logic [DW-1:0] w_sum;

    always_comb begin
        w_mag = a_i[DW-2:0];
        w_sum = {1'b0, w_mag} + ONE;
        if (!en_i) begin
            y_o = (w_mag == '0) ? '0 : a_i;
        end else if (a_i[DW-1]) begin
            y_o = {1'b1, (w_sum[DW-1] ? MAX_MAG : w_sum[DW-2:0])};
        end else if ({1'b0, w_mag} >= ONE) begin
            y_o = {1'b0, w_mag - ONE[DW-2:0]};
        end else begin
            // mag < ONE here, so the result magnitude is never zero
            y_o = {1'b1, ONE[DW-2:0] - w_mag};
        end
    end

endmodule

`default_nettype wire

// File: rtl/fc_train_seq.sv
// fc_train_seq: sequences one FC-layer sample (forward, optional backprop, argmax).
// Rev 1.0
`default_nettype none

module fc_train_seq
    import fc_train_seq_pkg::*;
#(
    parameter int N_IN   = 1024,
    parameter int N_OUT  = 10,
    parameter int DW     = DEF_DW,
    parameter int FRAC   = DEF_FRAC,
    parameter int IN_AW  = 10,
    parameter int OUT_AW = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              train,
    input  logic [OUT_AW-1:0] label,
    output logic              busy,
    output logic              done,
    output logic [OUT_AW-1:0] pred,
    output logic [IN_AW-1:0]  img_addr,
    input  logic [DW-1:0]     img_rdata,
    output logic              lyr_forward,
    output logic              lyr_in_valid,
    input  logic              lyr_in_rdy,
    output logic [DW-1:0]     lyr_in_data,
    output logic [IN_AW-1:0]  lyr_in_idx,
    input  logic              lyr_out_valid,
    output logic              lyr_out_rdy,
    input  logic [DW-1:0]     lyr_out_data,
    input  logic [IN_AW-1:0]  lyr_out_idx
);

    localparam int               BW       = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam int               CMPW     = IN_AW + OUT_AW;
    localparam logic [IN_AW-1:0] LAST_IN  = IN_AW'(N_IN - 1);
    localparam logic [IN_AW-1:0] LAST_OUT = IN_AW'(N_OUT - 1);
    localparam logic [IN_AW:0]   N_OUT_W  = (IN_AW + 1)'(N_OUT);

    state_e            state_q, state_d;
    logic [IN_AW-1:0]  k_q, k_d;
    logic [IN_AW-1:0]  cnt_q, cnt_d;
    logic [OUT_AW-1:0] pred_q, pred_d;
    logic [DW-1:0]     best_q, best_d;
    logic              train_q;
    logic [OUT_AW-1:0] label_q;
    logic [DW-1:0]     out_buf [N_OUT];

    logic              w_buf_we;
    logic              w_take;
    logic              w_is_label;
    logic [DW-1:0]     w_err;

    // Ordered value of a sign-magnitude word; -0 and +0 both map to 0.
    function automatic logic signed [DW:0] sm_val(input logic [DW-1:0] v);
        logic signed [DW:0] m;
        m = $signed({2'b00, v[DW-2:0]});
        sm_val = v[DW-1] ? -m : m;
    endfunction

    assign w_is_label = (CMPW'(label_q) == CMPW'(k_q));

    sm_sub_one #(.DW(DW), .FRAC(FRAC)) u_sub (
        .a_i  (out_buf[k_q[BW-1:0]]),
        .en_i (w_is_label),
        .y_o  (w_err)
    );

    always_comb begin
        state_d      = state_q;
        k_d          = k_q;
        cnt_d        = cnt_q;
        pred_d       = pred_q;
        best_d       = best_q;
        w_buf_we     = 1'b0;
        w_take       = 1'b0;
        busy         = 1'b1;
        done         = 1'b0;
        lyr_forward  = 1'b1;
        lyr_in_valid = 1'b0;
        lyr_in_data  = '0;
        lyr_in_idx   = '0;
        lyr_out_rdy  = 1'b0;
        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_d = S_FW_FETCH;
                    k_d     = '0;
                    cnt_d   = '0;
                    pred_d  = '0;
                    best_d  = '0;
                end
            end
            S_FW_FETCH: state_d = S_FW_SEND;
            S_FW_SEND: begin
                lyr_in_valid = 1'b1;
                lyr_in_data  = img_rdata;
                lyr_in_idx   = k_q;
                if (lyr_in_rdy) begin
                    k_d     = (k_q == LAST_IN) ? '0 : k_q + 1'b1;
                    state_d = (k_q == LAST_IN) ? S_FW_REC : S_FW_FETCH;
                end
            end
            S_FW_REC: begin
                lyr_out_rdy = 1'b1;
                if (lyr_out_valid && ({1'b0, lyr_out_idx} < N_OUT_W)) begin
                    w_buf_we = 1'b1;
                    // Beats may arrive out of order, so equal values still defer to the lower index
                    w_take = (cnt_q == '0)
                          || (sm_val(lyr_out_data) > sm_val(best_q))
                          || ((sm_val(lyr_out_data) == sm_val(best_q))
                              && (lyr_out_idx < IN_AW'(pred_q)));
                    if (w_take) begin
                        pred_d = OUT_AW'(lyr_out_idx);
                        best_d = lyr_out_data;
                    end
                    if (cnt_q == LAST_OUT) begin
                        cnt_d   = '0;
                        state_d = train_q ? S_BP_SEND : S_DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_BP_SEND: begin
                lyr_forward  = 1'b0;
                lyr_in_valid = 1'b1;
                lyr_in_data  = w_err;
                lyr_in_idx   = k_q;
                if (lyr_in_rdy) begin
                    k_d     = (k_q == LAST_OUT) ? '0 : k_q + 1'b1;
                    state_d = (k_q == LAST_OUT) ? S_BP_REC : S_BP_SEND;
                end
            end
            S_BP_REC: begin
                lyr_forward = 1'b0;
                lyr_out_rdy = 1'b1;
                if (lyr_out_valid) begin
                    cnt_d   = (cnt_q == LAST_IN) ? '0 : cnt_q + 1'b1;
                    state_d = (cnt_q == LAST_IN) ? S_DONE : S_BP_REC;
                end
            end
            S_DONE: begin
                busy    = 1'b0;
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                busy    = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    assign img_addr = k_q;
    assign pred     = pred_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            cnt_q   <= '0;
            pred_q  <= '0;
            best_q  <= '0;
            train_q <= 1'b0;
            label_q <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
            pred_q  <= pred_d;
            best_q  <= best_d;
            if (state_q == S_IDLE && start) begin
                train_q <= train;
                label_q <= label;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_buf_we) begin
            out_buf[lyr_out_idx[BW-1:0]] <= lyr_out_data;
        end
    end

endmodule

`default_nettype wire
